// File: rtl/wb_trace_checker.sv
`timescale 1ns/1ps
// wb_trace_checker: in-order checker of expected writeback / PC events against live pipeline taps.
// Ports: exp_* loads the entry list in IDLE; start_i runs it against wb_valid_i/wb_reg_i/wb_val_i/pc_i;
//        busy_o/done_o/error_o, pass/fail counters and first-error details (idx, observed value, timeout flag) are registered.
module wb_trace_checker #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 4,
    parameter int DEPTH  = 64,
    parameter int TMO_W  = 8,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              exp_valid_i,
    output logic              exp_ready_o,
    input  logic              exp_kind_i,
    input  logic              exp_regchk_i,
    input  logic [REG_W-1:0]  exp_reg_i,
    input  logic [DATA_W-1:0] exp_val_i,
    input  logic              start_i,
    input  logic              stop_on_err_i,
    input  logic              wb_valid_i,
    input  logic [REG_W-1:0]  wb_reg_i,
    input  logic [DATA_W-1:0] wb_val_i,
    input  logic [DATA_W-1:0] pc_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [CNT_W-1:0]  pass_cnt_o,
    output logic [CNT_W-1:0]  fail_cnt_o,
    output logic [IDX_W-1:0]  err_idx_o,
    output logic [DATA_W-1:0] err_got_o,
    output logic              err_tmo_o
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Last cycle an entry may wait: failing here means the wait counter would reach 2**TMO_W-1.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((2 ** TMO_W) - 2);

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   rd_idx;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               stop_lat;

    logic               mem_kind   [DEPTH];
    logic               mem_regchk [DEPTH];
    logic [REG_W-1:0]   mem_reg    [DEPTH];
    logic [DATA_W-1:0]  mem_val    [DEPTH];

    logic               wr_en;
    logic [CNT_W-1:0]   count_nxt;
    logic               launch;
    logic               cur_kind;
    logic               cur_regchk;
    logic [REG_W-1:0]   cur_reg;
    logic [DATA_W-1:0]  cur_val;
    logic               wb_hit;
    logic               wb_ok;
    logic               pass_now;
    logic               fail_now;
    logic               resolve;
    logic               last;

    assign exp_ready_o = (state == IDLE) && (count < CNT_W'(DEPTH));
    assign wr_en       = exp_valid_i && exp_ready_o && !clear_i;
    assign count_nxt   = wr_en ? count + CNT_W'(1) : count;
    // start in RUN is ignored; in IDLE an entry written in the same cycle joins the run.
    assign launch      = start_i && (state != RUN);

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_kind[count[IDX_W-1:0]]   <= exp_kind_i;
            mem_regchk[count[IDX_W-1:0]] <= exp_regchk_i;
            mem_reg[count[IDX_W-1:0]]    <= exp_reg_i;
            mem_val[count[IDX_W-1:0]]    <= exp_val_i;
        end
    end

    assign cur_kind   = mem_kind[rd_idx[IDX_W-1:0]];
    assign cur_regchk = mem_regchk[rd_idx[IDX_W-1:0]];
    assign cur_reg    = mem_reg[rd_idx[IDX_W-1:0]];
    assign cur_val    = mem_val[rd_idx[IDX_W-1:0]];

    // Writebacks only resolve writeback entries; PC entries ignore them entirely.
    assign wb_hit   = !cur_kind && wb_valid_i;
    assign wb_ok    = (wb_val_i == cur_val) && (!cur_regchk || (wb_reg_i == cur_reg));
    assign pass_now = (cur_kind && (pc_i == cur_val)) || (wb_hit && wb_ok);
    // A match in the expiry cycle wins over the timeout.
    assign fail_now = (wb_hit && !wb_ok) || (!pass_now && !wb_hit && (tmo_cnt == TMO_LAST));
    assign resolve  = pass_now || fail_now;
    assign last     = (rd_idx + CNT_W'(1)) == count;

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            rd_idx     <= '0;
            tmo_cnt    <= '0;
            stop_lat   <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            error_o    <= 1'b0;
            pass_cnt_o <= '0;
            fail_cnt_o <= '0;
            err_idx_o  <= '0;
            err_got_o  <= '0;
            err_tmo_o  <= 1'b0;
        end else if (clear_i) begin
            state      <= IDLE;
            count      <= '0;
            rd_idx     <= '0;
            tmo_cnt    <= '0;
            stop_lat   <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            error_o    <= 1'b0;
            pass_cnt_o <= '0;
            fail_cnt_o <= '0;
            err_idx_o  <= '0;
            err_got_o  <= '0;
            err_tmo_o  <= 1'b0;
        end else begin
            if (wr_en) begin
                count <= count_nxt;
            end
            if (launch) begin
                rd_idx     <= '0;
                tmo_cnt    <= '0;
                pass_cnt_o <= '0;
                fail_cnt_o <= '0;
                error_o    <= 1'b0;
                err_idx_o  <= '0;
                err_got_o  <= '0;
                err_tmo_o  <= 1'b0;
                stop_lat   <= stop_on_err_i;
                if (count_nxt == '0) begin
                    state  <= DONE;
                    busy_o <= 1'b0;
                    done_o <= 1'b1;
                end else begin
                    state  <= RUN;
                    busy_o <= 1'b1;
                    done_o <= 1'b0;
                end
            end else if (state == RUN) begin
                if (resolve) begin
                    tmo_cnt <= '0;
                    rd_idx  <= rd_idx + CNT_W'(1);
                    if (pass_now) begin
                        pass_cnt_o <= pass_cnt_o + CNT_W'(1);
                    end else begin
                        fail_cnt_o <= fail_cnt_o + CNT_W'(1);
                        if (!error_o) begin
                            error_o   <= 1'b1;
                            err_idx_o <= rd_idx[IDX_W-1:0];
                            err_got_o <= wb_hit ? wb_val_i : pc_i;
                            err_tmo_o <= !wb_hit;
                        end
                    end
                    if (last || (!pass_now && stop_lat)) begin
                        state  <= DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                end else begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_trace_checker.sv
`timescale 1ns/1ps
module tb_wb_trace_checker;

    localparam int DATA_W = 16;
    localparam int REG_W  = 4;
    localparam int DEPTH  = 8;
    localparam int TMO_W  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int LIM    = (1 << TMO_W) - 1;
    localparam int PADLEN = 140;

    logic              clk_i = 1'b0;
    logic              reset = 1'b1;
    logic              clear_i = 1'b0;
    logic              exp_valid_i = 1'b0;
    logic              exp_ready_o;
    logic              exp_kind_i = 1'b0;
    logic              exp_regchk_i = 1'b0;
    logic [REG_W-1:0]  exp_reg_i = '0;
    logic [DATA_W-1:0] exp_val_i = '0;
    logic              start_i = 1'b0;
    logic              stop_on_err_i = 1'b0;
    logic              wb_valid_i = 1'b0;
    logic [REG_W-1:0]  wb_reg_i = '0;
    logic [DATA_W-1:0] wb_val_i = '0;
    logic [DATA_W-1:0] pc_i = '1;
    logic              busy_o, done_o, error_o, err_tmo_o;
    logic [CNT_W-1:0]  pass_cnt_o, fail_cnt_o;
    logic [IDX_W-1:0]  err_idx_o;
    logic [DATA_W-1:0] err_got_o;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference entry list and per-cycle input trace for a run.
    bit m_kind[$];
    bit m_rchk[$];
    int m_reg[$];
    int m_val[$];
    bit t_wbv[$];
    int t_reg[$];
    int t_val[$];
    int t_pc[$];

    wb_trace_checker #(.DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH), .TMO_W(TMO_W)) dut (
        .clk_i(clk_i), .reset(reset), .clear_i(clear_i),
        .exp_valid_i(exp_valid_i), .exp_ready_o(exp_ready_o), .exp_kind_i(exp_kind_i),
        .exp_regchk_i(exp_regchk_i), .exp_reg_i(exp_reg_i), .exp_val_i(exp_val_i),
        .start_i(start_i), .stop_on_err_i(stop_on_err_i),
        .wb_valid_i(wb_valid_i), .wb_reg_i(wb_reg_i), .wb_val_i(wb_val_i), .pc_i(pc_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
        .pass_cnt_o(pass_cnt_o), .fail_cnt_o(fail_cnt_o),
        .err_idx_o(err_idx_o), .err_got_o(err_got_o), .err_tmo_o(err_tmo_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        m_kind.delete(); m_rchk.delete(); m_reg.delete(); m_val.delete();
    endtask

    task automatic set_entry(input bit kind, input bit rchk, input int rg, input int val, input bit keep);
        exp_kind_i   = kind;
        exp_regchk_i = rchk;
        exp_reg_i    = REG_W'(rg);
        exp_val_i    = DATA_W'(val);
        exp_valid_i  = 1'b1;
        if (keep && m_val.size() < DEPTH) begin
            m_kind.push_back(kind); m_rchk.push_back(rchk); m_reg.push_back(rg); m_val.push_back(val);
        end
    endtask

    task automatic load_entry(input bit kind, input bit rchk, input int rg, input int val, input bit keep);
        set_entry(kind, rchk, rg, val, keep);
        tick();
        exp_valid_i = 1'b0;
    endtask

    task automatic t_clear();
        t_wbv.delete(); t_reg.delete(); t_val.delete(); t_pc.delete();
    endtask

    task automatic t_add(input bit wbv, input int rg, input int val, input int pc);
        t_wbv.push_back(wbv); t_reg.push_back(rg); t_val.push_back(val); t_pc.push_back(pc);
    endtask

    // Idle padding uses a pc that no entry in this bench ever expects.
    task automatic t_pad();
        while (t_wbv.size() < PADLEN) t_add(1'b0, 0, 0, 16'hFFFF);
    endtask

    // Starts a run (together with any entry write the caller has set up) and
    // plays the trace; dcyc is the trace cycle after whose edge done_o first showed.
    task automatic do_run(input bit stop, input int start_at, output int dcyc);
        start_i = 1'b1;
        stop_on_err_i = stop;
        tick();
        start_i = 1'b0;
        exp_valid_i = 1'b0;
        dcyc = -1;
        for (int c = 0; c < t_wbv.size(); c++) begin
            wb_valid_i = t_wbv[c];
            wb_reg_i   = REG_W'(t_reg[c]);
            wb_val_i   = DATA_W'(t_val[c]);
            pc_i       = DATA_W'(t_pc[c]);
            start_i    = (c == start_at);
            tick();
            if (done_o === 1'b1 && dcyc < 0) dcyc = c;
        end
        start_i = 1'b0;
        wb_valid_i = 1'b0;
        pc_i = '1;
    endtask

    // Walks the trace entry by entry: each entry waits until it matches, a
    // writeback decides it, or it has waited LIM cycles without a match.
    task automatic model(input bit stop, output int ep, output int ef, output int eerr,
                         output int eidx, output int egot, output int etmo, output int edone);
        int idx, waited, got, n;
        bit res, ok, tmo;
        ep = 0; ef = 0; eerr = 0; eidx = 0; egot = 0; etmo = 0; edone = -1;
        idx = 0; waited = 0; n = m_val.size();
        for (int c = 0; c < t_wbv.size(); c++) begin
            res = 0; ok = 0; tmo = 0; got = 0;
            if (m_kind[idx]) begin
                if (t_pc[c] == m_val[idx]) begin res = 1; ok = 1; end
            end else if (t_wbv[c]) begin
                res = 1;
                ok = (t_val[c] == m_val[idx]) && (!m_rchk[idx] || t_reg[c] == m_reg[idx]);
                got = t_val[c];
            end
            waited++;
            if (!res && waited == LIM) begin res = 1; ok = 0; tmo = 1; got = t_pc[c]; end
            if (res) begin
                if (ok) ep++;
                else begin
                    ef++;
                    if (eerr == 0) begin eerr = 1; eidx = idx; egot = got; etmo = tmo; end
                end
                idx++;
                waited = 0;
                if (idx == n || (!ok && stop)) begin edone = c; break; end
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        reset = 1'b0;
        tick();
        n_cmp++; if (exp_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", exp_ready_o); end
        n_cmp++; if ({busy_o, done_o, error_o, err_tmo_o} !== 4'b0) begin n_fail++; $display("FAIL rst_flags: got %b want 0000", {busy_o, done_o, error_o, err_tmo_o}); end
        n_cmp++; if ({pass_cnt_o, fail_cnt_o, err_idx_o, err_got_o} !== '0) begin n_fail++; $display("FAIL rst_fields: got %h want 0", {pass_cnt_o, fail_cnt_o, err_idx_o, err_got_o}); end
    endtask

    task automatic test_in_order_wb();
        int dc;
        do_clear();
        load_entry(0, 0, 0, 3, 1);
        load_entry(0, 0, 0, 1, 1);
        set_entry(0, 0, 0, 2, 1);          // third entry written in the start cycle
        t_clear();
        t_add(1, 7, 3, 16'hFFFF); t_add(1, 8, 1, 16'hFFFF); t_add(1, 9, 2, 16'hFFFF);
        t_pad();
        do_run(0, -1, dc);
        n_cmp++; if (dc !== 2) begin n_fail++; $display("FAIL wb_done_cycle: got %0d want 2", dc); end
        n_cmp++; if (pass_cnt_o !== CNT_W'(3)) begin n_fail++; $display("FAIL wb_pass: got %0d want 3", pass_cnt_o); end
        n_cmp++; if (fail_cnt_o !== CNT_W'(0)) begin n_fail++; $display("FAIL wb_fail: got %0d want 0", fail_cnt_o); end
        n_cmp++; if (error_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL wb_err_busy: got %b%b want 00", error_o, busy_o); end
    endtask

    task automatic test_pc_and_regchk();
        int dc;
        do_clear();
        load_entry(1, 0, 0, 6, 1);
        load_entry(0, 1, 4, 16'h3925, 1);
        t_clear();
        for (int p = 0; p <= 6; p++) t_add(0, 0, 0, p);
        t_add(1, 5, 16'h3925, 16'hFFFF);
        t_pad();
        do_run(0, 2, dc);                  // start pulse mid-run must be ignored
        n_cmp++; if (dc !== 7) begin n_fail++; $display("FAIL pc_done_cycle: got %0d want 7", dc); end
        n_cmp++; if (pass_cnt_o !== CNT_W'(1) || fail_cnt_o !== CNT_W'(1)) begin n_fail++; $display("FAIL pc_counts: got %0d/%0d want 1/1", pass_cnt_o, fail_cnt_o); end
        n_cmp++; if (err_idx_o !== IDX_W'(1)) begin n_fail++; $display("FAIL pc_err_idx: got %0d want 1", err_idx_o); end
        n_cmp++; if (err_got_o !== 16'h3925) begin n_fail++; $display("FAIL pc_err_got: got %h want 3925", err_got_o); end
        n_cmp++; if (err_tmo_o !== 1'b0 || error_o !== 1'b1) begin n_fail++; $display("FAIL pc_err_flags: got tmo=%b err=%b want 0/1", err_tmo_o, error_o); end
    endtask

    task automatic test_timeout();
        int dc;
        do_clear();
        load_entry(1, 0, 0, 20, 1);
        t_clear();
        for (int i = 0; i < 20; i++) t_add(0, 0, 0, 7);
        t_pad();
        do_run(0, -1, dc);
        n_cmp++; if (dc !== LIM - 1) begin n_fail++; $display("FAIL tmo_done_cycle: got %0d want %0d", dc, LIM - 1); end
        n_cmp++; if (err_tmo_o !== 1'b1 || done_o !== 1'b1) begin n_fail++; $display("FAIL tmo_flags: got tmo=%b done=%b want 1/1", err_tmo_o, done_o); end
        n_cmp++; if (err_got_o !== 16'd7) begin n_fail++; $display("FAIL tmo_err_got: got %0d want 7", err_got_o); end
        n_cmp++; if (fail_cnt_o !== CNT_W'(1) || pass_cnt_o !== CNT_W'(0)) begin n_fail++; $display("FAIL tmo_counts: got %0d/%0d want 0/1", pass_cnt_o, fail_cnt_o); end
    endtask

    task automatic test_stop_on_err();
        int dc;
        do_clear();
        for (int i = 0; i < 3; i++) load_entry(0, 0, 0, 5, 1);
        t_clear();
        t_add(1, 0, 4, 16'hFFFF); t_add(1, 0, 5, 16'hFFFF); t_add(1, 0, 5, 16'hFFFF);
        t_pad();
        do_run(1, -1, dc);
        n_cmp++; if (dc !== 0) begin n_fail++; $display("FAIL stop_done_cycle: got %0d want 0", dc); end
        n_cmp++; if (pass_cnt_o !== CNT_W'(0) || fail_cnt_o !== CNT_W'(1)) begin n_fail++; $display("FAIL stop_counts: got %0d/%0d want 0/1", pass_cnt_o, fail_cnt_o); end
        n_cmp++; if (err_got_o !== 16'd4 || err_idx_o !== '0) begin n_fail++; $display("FAIL stop_err: got val=%0d idx=%0d want 4/0", err_got_o, err_idx_o); end
        n_cmp++; if (exp_ready_o !== 1'b0) begin n_fail++; $display("FAIL done_ready: got %b want 0", exp_ready_o); end
        load_entry(0, 0, 0, 9, 0);         // must be ignored in DONE
        t_clear();
        for (int i = 0; i < 3; i++) t_add(1, 0, 5, 16'hFFFF);
        t_pad();
        do_run(1, -1, dc);
        n_cmp++; if (dc !== 2) begin n_fail++; $display("FAIL rerun_done_cycle: got %0d want 2", dc); end
        n_cmp++; if (pass_cnt_o !== CNT_W'(3) || fail_cnt_o !== CNT_W'(0)) begin n_fail++; $display("FAIL rerun_counts: got %0d/%0d want 3/0", pass_cnt_o, fail_cnt_o); end
        n_cmp++; if (error_o !== 1'b0) begin n_fail++; $display("FAIL rerun_error: got %b want 0", error_o); end
    endtask

    task automatic test_fill();
        int dc;
        int rg;
        do_clear();
        t_clear();
        for (int i = 0; i <= DEPTH; i++) begin
            n_cmp++; if (exp_ready_o !== (i < DEPTH)) begin n_fail++; $display("FAIL fill_ready_%0d: got %b want %b", i, exp_ready_o, i < DEPTH); end
            rg = $urandom_range(0, 15);
            if (i < DEPTH) begin
                if (i % 2 == 1) t_add(0, 0, 0, i + 1);
                else t_add(1, rg, i + 1, 16'hFFFF);
            end
            load_entry(i % 2 == 1, $urandom_range(0, 1), rg, (i < DEPTH) ? i + 1 : 3, 1);
        end
        t_pad();
        do_run(0, -1, dc);
        n_cmp++; if (dc !== DEPTH - 1) begin n_fail++; $display("FAIL fill_done_cycle: got %0d want %0d", dc, DEPTH - 1); end
        n_cmp++; if (pass_cnt_o !== CNT_W'(DEPTH) || fail_cnt_o !== '0) begin n_fail++; $display("FAIL fill_counts: got %0d/%0d want %0d/0", pass_cnt_o, fail_cnt_o, DEPTH); end
    endtask

    task automatic test_reset_midrun();
        do_clear();
        for (int i = 0; i < 4; i++) load_entry(0, 0, 0, 10 + i, 1);
        start_i = 1'b1; tick(); start_i = 1'b0;
        wb_valid_i = 1'b1; wb_val_i = 16'd10; tick();
        wb_val_i = 16'd11; tick();
        wb_valid_i = 1'b0;
        n_cmp++; if (pass_cnt_o !== CNT_W'(2) || busy_o !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got pass=%0d busy=%b want 2/1", pass_cnt_o, busy_o); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if ({busy_o, done_o, error_o, err_tmo_o, pass_cnt_o, fail_cnt_o, err_idx_o, err_got_o} !== '0 || exp_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL mid_reset: got busy=%b done=%b pass=%0d ready=%b want 0/0/0/1", busy_o, done_o, pass_cnt_o, exp_ready_o);
        end
        @(posedge clk_i); #1;
        reset = 1'b0;
        m_val.delete();
        start_i = 1'b1; tick(); start_i = 1'b0;
        n_cmp++; if (done_o !== 1'b1 || busy_o !== 1'b0) begin n_fail++; $display("FAIL empty_run: got done=%b busy=%b want 1/0", done_o, busy_o); end
        n_cmp++; if (pass_cnt_o !== '0 || fail_cnt_o !== '0) begin n_fail++; $display("FAIL empty_counts: got %0d/%0d want 0/0", pass_cnt_o, fail_cnt_o); end
    endtask

    task automatic test_random();
        int n, dens, dc, ep, ef, eerr, eidx, egot, etmo, edone;
        bit stop, kind;
        for (int it = 0; it < 20; it++) begin
            do_clear();
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) begin
                kind = $urandom_range(0, 1);
                load_entry(kind, $urandom_range(0, 1), $urandom_range(0, 3), kind ? $urandom_range(0, 7) : $urandom_range(0, 3), 1);
            end
            for (int rep = 0; rep < 2; rep++) begin
                dens = $urandom_range(0, 5);
                stop = $urandom_range(0, 1);
                t_clear();
                for (int c = 0; c < 60; c++)
                    t_add($urandom_range(0, 7) < dens, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7));
                t_pad();
                model(stop, ep, ef, eerr, eidx, egot, etmo, edone);
                do_run(stop, -1, dc);
                n_cmp++; if (dc !== edone) begin n_fail++; $display("FAIL rnd%0d_%0d_done: got %0d want %0d", it, rep, dc, edone); end
                n_cmp++; if (pass_cnt_o !== CNT_W'(ep) || fail_cnt_o !== CNT_W'(ef)) begin n_fail++; $display("FAIL rnd%0d_%0d_counts: got %0d/%0d want %0d/%0d", it, rep, pass_cnt_o, fail_cnt_o, ep, ef); end
                n_cmp++; if (error_o !== eerr[0] || err_tmo_o !== etmo[0]) begin n_fail++; $display("FAIL rnd%0d_%0d_flags: got err=%b tmo=%b want %0d/%0d", it, rep, error_o, err_tmo_o, eerr, etmo); end
                n_cmp++; if (err_idx_o !== IDX_W'(eidx) || err_got_o !== DATA_W'(egot)) begin n_fail++; $display("FAIL rnd%0d_%0d_errinfo: got idx=%0d val=%0d want %0d/%0d", it, rep, err_idx_o, err_got_o, eidx, egot); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_in_order_wb();
        test_pc_and_regchk();
        test_timeout();
        test_stop_on_err();
        test_fill();
        test_reset_midrun();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_trace_checker.md
Name: wb_trace_checker

Overview:
- Parametrised, synthesizable self-check monitor for the pipelined CPU/AES top.
- Holds a programmable list of expected events: register writebacks (Rd, Rd_val) and PC arrivals.
- Matches the list in order against the live pipeline outputs, with a per-entry timeout, so checking no longer depends on fixed cycle counts.
- Sits beside cpu_pipeline_aes, driven by its pc_o/Rd_o/Rd_val taps; reports pass/fail counts and first-error details.

Parameters:
- DATA_W, 16, width of Rd_val, pc and expected values.
- REG_W, 4, width of register index.
- DEPTH, 64, max expected entries; must be >= 2.
- TMO_W, 8, timeout counter width; limit is 2**TMO_W-1 cycles.

Ports:
- clk_i  in  1  clock, all state on posedge.
- reset  in  1  asynchronous active-high reset.
- clear_i  in  1  sync flush: entry list emptied, counters zeroed, state -> IDLE.
- exp_valid_i  in  1  expected-entry write request.
- exp_ready_o  out  1  high only in IDLE with fewer than DEPTH entries.
- exp_kind_i  in  1  0 = writeback check, 1 = PC check.
- exp_regchk_i  in  1  kind 0 only: also compare register index.
- exp_reg_i  in  REG_W  expected Rd.
- exp_val_i  in  DATA_W  expected Rd_val (kind 0) or pc (kind 1).
- start_i  in  1  begin a run over all loaded entries.
- stop_on_err_i  in  1  sampled at start; 1 = halt at first failure.
- wb_valid_i  in  1  a writeback occurs this cycle.
- wb_reg_i  in  REG_W  writeback Rd.
- wb_val_i  in  DATA_W  writeback Rd_val.
- pc_i  in  DATA_W  current pc.
- busy_o  out  1  high in RUN.
- done_o  out  1  high in DONE; held until start_i or clear_i.
- error_o  out  1  sticky: at least one failure this run.
- pass_cnt_o  out  $clog2(DEPTH+1)  entries passed.
- fail_cnt_o  out  $clog2(DEPTH+1)  entries failed.
- err_idx_o  out  $clog2(DEPTH)  index of first failing entry.
- err_got_o  out  DATA_W  observed value at first failure: wb_val_i, or pc_i on timeout.
- err_tmo_o  out  1  first failure was a timeout.

Behaviour:
- Reset and clear values: all outputs 0, except exp_ready_o = 1. Entry count 0, read index 0, state IDLE.
- States: IDLE, RUN, DONE.
- IDLE:
  - exp_valid_i & exp_ready_o stores the entry at index count, then count++.
  - start_i -> RUN. Read index, counters, error fields and timeout all zeroed; stop_on_err latched.
  - start_i with count 0 -> DONE next cycle, both counts 0.
  - start_i and exp_valid_i in the same cycle: the entry is stored first and is included in the run.
- RUN, per cycle, against the current entry e:
  - kind 0, wb_valid_i = 1: pass if wb_val_i == e.val and (!e.regchk or wb_reg_i == e.reg), else fail. The entry resolves either way.
  - kind 0, wb_valid_i = 0: no resolution; timeout increments.
  - kind 1: pass when pc_i == e.val; writebacks are ignored. Timeout increments otherwise.
  - Timeout reaching 2**TMO_W-1 with no pass: fail, err_tmo = 1, entry resolves.
  - A match in the same cycle as timeout expiry counts as a pass.
  - On resolve: pass_cnt or fail_cnt increments at the next edge, timeout -> 0, read index++.
  - One entry at most resolves per cycle; back-to-back writebacks resolve consecutive entries on consecutive cycles.
  - First failure only: err_idx/err_got/err_tmo captured, error_o set. Later failures only increment fail_cnt.
  - Last entry resolved, or a failure with stop_on_err -> DONE at the next edge.
- DONE:
  - Entries are retained. start_i reruns the list with counters re-zeroed.
  - exp_valid_i is ignored; exp_ready_o = 0.
- start_i during RUN is ignored. clear_i takes priority over every other input in all states.
- Async reset mid-run: immediate return to reset values; entries are discarded.
- Latency: event at edge N -> count or state update visible after edge N+1. No combinational path from wb_*/pc_i to any output.
- Counters cannot overflow: pass_cnt + fail_cnt <= count <= DEPTH.

Test Plan:
- Load 3 kind-0 entries {3, 1, 2}, regchk = 0. Start, then writebacks 3, 1, 2 on consecutive cycles -> done_o 1 cycle after the third; pass_cnt = 3, fail_cnt = 0, error_o = 0.
- Load kind-1 pc = 6 and kind-0 val = 16'h3925, reg = 4, regchk = 1. Drive pc 0..6, then writeback reg = 5, val = 16'h3925 -> pass = 1, fail = 1, err_idx = 1, err_got = 16'h3925, err_tmo = 0.
- TMO_W = 4, one kind-1 entry pc = 20, pc held at 7 -> fail at the 15th cycle; err_tmo = 1, err_got = 7, done_o set.
- stop_on_err = 1, entries {5, 5, 5}, writebacks 4, 5, 5 -> DONE after the first; pass = 0, fail = 1. A rerun with correct data -> pass = 3, error_o = 0.
- Load DEPTH entries -> exp_ready_o falls after the DEPTH-th write; an extra write is not counted; a run with all matches gives pass_cnt = DEPTH.
- Assert reset mid-run after 2 passes -> all outputs 0 immediately; a start with no reload -> done with both counts 0.
